// File: rtl/fp_addsub.sv
// Multi-cycle IEEE 754 adder/subtractor with round-to-nearest-even, flush-to-zero and exception flags.
// One operation is in flight at a time; both ports use a valid/ready handshake.
module fp_addsub #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags,
  output logic [2:0]   state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable until then, and the consumer may drive
  // ready independently of valid.

  localparam int SIG_W  = MAN_W + 4;
  localparam int SUM_W  = MAN_W + 5;
  localparam int XW     = EXP_W + 2;
  localparam int SH_MAX = MAN_W + 3;
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic signed [XW-1:0] EXP_INF  = XW'((1 << EXP_W) - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    ROUND = 3'd4,
    OUT   = 3'd5
  } state_t;

  state_t state, state_next;

  logic                    sa, sb, sr;
  logic [EXP_W-1:0]        ea, eb;
  logic [SIG_W-1:0]        ma, mb, nsig;
  logic signed [XW-1:0]    er;
  logic [SUM_W-1:0]        sum_q;
  logic [W-1:0]            result_q;
  logic [3:0]              flags_q;

  // Operand decode; b carries its effective sign after op is applied.
  logic             a_sign, b_sign;
  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  assign a_sign = a[W-1];
  assign b_sign = b[W-1] ^ op;
  assign a_exp  = a[W-2:MAN_W];
  assign b_exp  = b[W-2:MAN_W];
  assign a_frac = a[MAN_W-1:0];
  assign b_frac = b[MAN_W-1:0];
  assign a_nan  = (&a_exp) && (|a_frac);
  assign a_inf  = (&a_exp) && !(|a_frac);
  assign a_zero = !(|a_exp);
  assign b_nan  = (&b_exp) && (|b_frac);
  assign b_inf  = (&b_exp) && !(|b_frac);
  assign b_zero = !(|b_exp);

  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [3:0]   spec_flags;

  always_comb begin
    spec_hit   = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    spec_res   = a;
    spec_flags = 4'b0000;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if (a_inf && b_inf) begin
      if (a_sign != b_sign) begin
        spec_res   = QNAN;
        spec_flags = 4'b1000;
      end else begin
        spec_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      spec_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_res = {a_sign & b_sign, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_res = {b_sign, b_exp, b_frac};
    end
  end

  // Alignment: the smaller-exponent significand is shifted right with sticky.
  logic             a_small, sh_sticky;
  logic [EXP_W-1:0] ediff;
  logic [SIG_W-1:0] sh_in, sh_out;
  int               sh_amt;

  always_comb begin
    a_small   = ea < eb;
    ediff     = a_small ? (eb - ea) : (ea - eb);
    sh_in     = a_small ? ma : mb;
    sh_amt    = (int'(ediff) > SH_MAX) ? SH_MAX : int'(ediff);
    sh_sticky = 1'b0;
    for (int i = 0; i < SIG_W; i++) begin
      if (i < sh_amt) sh_sticky = sh_sticky | sh_in[i];
    end
    sh_out    = sh_in >> sh_amt;
    sh_out[0] = sh_out[0] | sh_sticky;
  end

  logic [SUM_W-1:0] add_sum;
  logic             add_sign, add_zero;

  always_comb begin
    add_sum  = '0;
    add_sign = sa;
    if (sa == sb) begin
      add_sum = {1'b0, ma} + {1'b0, mb};
    end else if (ma >= mb) begin
      add_sum = {1'b0, ma} - {1'b0, mb};
    end else begin
      add_sum  = {1'b0, mb} - {1'b0, ma};
      add_sign = sb;
    end
    add_zero = (add_sum == '0);
  end

  logic [SIG_W-1:0]     nrm_sig;
  logic signed [XW-1:0] nrm_exp;
  int                   lead, lzc;

  always_comb begin
    lead = 0;
    for (int i = 0; i < SIG_W; i++) begin
      if (sum_q[i]) lead = i;
    end
    lzc = SH_MAX - lead;
    if (sum_q[SUM_W-1]) begin
      nrm_sig    = sum_q[SUM_W-1:1];
      nrm_sig[0] = sum_q[1] | sum_q[0];
      nrm_exp    = er + EXP_ONE;
    end else begin
      nrm_sig = sum_q[SIG_W-1:0] << lzc;
      nrm_exp = er - XW'(lzc);
    end
  end

  // Round to nearest even on G/R/S below the stored fraction.
  logic                 g_bit, r_bit, s_bit, rnd_up, inexact;
  logic [MAN_W+1:0]     mant_r;
  logic [MAN_W-1:0]     rnd_frac;
  logic signed [XW-1:0] rnd_exp;
  logic [W-1:0]         rnd_res;
  logic [3:0]           rnd_flags;

  always_comb begin
    g_bit   = nsig[2];
    r_bit   = nsig[1];
    s_bit   = nsig[0];
    rnd_up  = g_bit && (r_bit || s_bit || nsig[3]);
    inexact = g_bit || r_bit || s_bit;
    mant_r  = {1'b0, nsig[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    if (mant_r[MAN_W+1]) begin
      rnd_exp  = er + EXP_ONE;
      rnd_frac = mant_r[MAN_W:1];
    end else begin
      rnd_exp  = er;
      rnd_frac = mant_r[MAN_W-1:0];
    end
    if (rnd_exp >= EXP_INF) begin
      rnd_res   = {sr, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flags = 4'b0101;
    end else if (rnd_exp[XW-1] || rnd_exp == '0) begin
      rnd_res   = {sr, {(W-1){1'b0}}};
      rnd_flags = 4'b0011;
    end else begin
      rnd_res   = {sr, rnd_exp[EXP_W-1:0], rnd_frac};
      rnd_flags = {3'b000, inexact};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = spec_hit ? OUT : ALIGN;
      ALIGN:   state_next = ADD;
      ADD:     state_next = add_zero ? OUT : NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= 1'b0;
      sb       <= 1'b0;
      sr       <= 1'b0;
      ea       <= '0;
      eb       <= '0;
      ma       <= '0;
      mb       <= '0;
      nsig     <= '0;
      er       <= '0;
      sum_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sa <= a_sign;
          sb <= b_sign;
          ea <= a_exp;
          eb <= b_exp;
          ma <= {1'b1, a_frac, 3'b000};
          mb <= {1'b1, b_frac, 3'b000};
          if (spec_hit) begin
            result_q <= spec_res;
            flags_q  <= spec_flags;
          end
        end
        ALIGN: begin
          if (a_small) begin
            ma <= sh_out;
            er <= {2'b00, eb};
          end else begin
            mb <= sh_out;
            er <= {2'b00, ea};
          end
        end
        ADD: begin
          sum_q <= add_sum;
          sr    <= add_sign;
          if (add_zero) begin
            result_q <= '0;
            flags_q  <= '0;
          end
        end
        NORM: begin
          nsig <= nrm_sig;
          er   <= nrm_exp;
        end
        ROUND: begin
          result_q <= rnd_res;
          flags_q  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign result    = result_q;
  assign flags     = flags_q;
  assign state_dbg = state;

endmodule
